// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: shared state, opcode and datapath-select encodings for the multicycle controller
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    function automatic logic op_supported(input logic [6:0] op);
        return op == OP_LW || op == OP_SW || op == OP_R || op == OP_I || op == OP_BR || op == OP_JAL;
    endfunction

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        return op == OP_SW ? 2'b01 : op == OP_BR ? 2'b10 : op == OP_JAL ? 2'b11 : 2'b00;
    endfunction

endpackage

// File: rtl/aludec.sv
// aludec: maps ALUOp and instruction function fields to an ALU operation
module aludec
    import multicycle_ctrl_pkg::*;
(
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] alu_op,
    output logic [2:0] alu_control
);

    // subtract only for R-type with funct7b5 set; immediates never encode sub
    always_comb begin
        alu_control = ALU_ADD;
        if (alu_op == ALUOP_SUB)
            alu_control = ALU_SUB;
        else if (alu_op == ALUOP_FUNCT)
            case (funct3)
                3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                3'b010:  alu_control = ALU_SLT;
                3'b110:  alu_control = ALU_OR;
                3'b111:  alu_control = ALU_AND;
                default: alu_control = ALU_ADD;
            endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM controller for a multicycle RV32 subset datapath
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       InstrDone,
    output logic       IllegalOp
);

    state_t     state_q, state_d;
    logic [1:0] alu_op;
    logic       pc_update, branch, ir_write, reg_write, mem_write, done;

    // next state; memory states wait on MemReady, unknown opcodes fall back to FETCH
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE:   case (op)
                            OP_LW, OP_SW: state_d = S_MEMADR;
                            OP_R:         state_d = S_EXECUTER;
                            OP_I:         state_d = S_EXECUTEI;
                            OP_BR:        state_d = S_BRANCH;
                            OP_JAL:       state_d = S_JAL;
                            default:      state_d = S_FETCH;
                        endcase
            S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = MemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = MemReady ? S_FETCH : S_MEMWRITE;
            S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // state register; reset forces FETCH without waiting for a clock edge
    always_ff @(posedge clk or negedge reset)
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;

    // per-state datapath controls and raw (ungated) write strobes
    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        done      = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        alu_op    = ALUOP_ADD;
        case (state_q)
            S_FETCH:    begin ir_write = MemReady; pc_update = MemReady; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURESULT; end
            S_DECODE:   begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_IMM; end
            S_MEMADR:   begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB:    begin ResultSrc = RES_DATA; reg_write = 1'b1; done = 1'b1; end
            S_MEMWRITE: begin AdrSrc = 1'b1; mem_write = 1'b1; done = MemReady; end
            S_EXECUTER: begin ALUSrcA = SRCA_RS1; alu_op = ALUOP_FUNCT; end
            S_EXECUTEI: begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; alu_op = ALUOP_FUNCT; end
            S_ALUWB:    begin reg_write = 1'b1; done = 1'b1; end
            S_BRANCH:   begin ALUSrcA = SRCA_RS1; alu_op = ALUOP_SUB; branch = 1'b1; done = 1'b1; end
            S_JAL:      begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_FOUR; pc_update = 1'b1; end
            default:    ;
        endcase
    end

    // strobes are forced low while reset is held so nothing is written during reset
    assign PCWrite   = reset & (pc_update | (branch & (Zero ^ funct3[0])));
    assign IRWrite   = reset & ir_write;
    assign RegWrite  = reset & reg_write;
    assign MemWrite  = reset & mem_write;
    assign InstrDone = reset & done;
    assign IllegalOp = reset & (state_q == S_DECODE) & ~op_supported(op);
    assign ImmSrc    = imm_src(op);

    aludec u_aludec (
        .op5        (op[5]),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .alu_op     (alu_op),
        .alu_control(ALUControl)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for the multicycle controller
module tb_multicycle_ctrl;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;
    localparam int T_F = 0, T_D = 1, T_ADR = 2, T_RD = 3, T_WB = 4, T_WR = 5;
    localparam int T_EXR = 6, T_EXI = 7, T_AWB = 8, T_BR = 9, T_J = 10;

    logic       clk = 1'b0, reset = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0, Zero = 1'b0, MemReady = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, InstrDone, IllegalOp;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int   n_checks = 0, n_fail = 0, cyc = 0;
    bit   mon_en = 1'b0;
    logic [17:0] exp_q[$];
    int          lat_q[$];

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .InstrDone(InstrDone), .IllegalOp(IllegalOp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic legal(input logic [6:0] o);
        return o inside {LW, SW, RT, IT, BR, JL};
    endfunction

    // expected outputs for one cycle of a given instruction step, straight from the output table
    function automatic logic [17:0] model(input int st, input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7, input logic z, input logic mr);
        logic pcu = 1'b0, br = 1'b0, adr = 1'b0, mw = 1'b0, irw = 1'b0, rw = 1'b0, dn = 1'b0, ill = 1'b0;
        logic [1:0] rs = 2'd0, sa = 2'd0, sb = 2'd0, imm;
        logic [2:0] alc;
        int aop = 0;
        case (st)
            T_F:   begin irw = mr; pcu = mr; sb = 2'd2; rs = 2'd2; end
            T_D:   begin sa = 2'd1; sb = 2'd1; ill = !legal(o); end
            T_ADR: begin sa = 2'd2; sb = 2'd1; end
            T_RD:  adr = 1'b1;
            T_WB:  begin rs = 2'd1; rw = 1'b1; dn = 1'b1; end
            T_WR:  begin adr = 1'b1; mw = 1'b1; dn = mr; end
            T_EXR: begin sa = 2'd2; aop = 2; end
            T_EXI: begin sa = 2'd2; sb = 2'd1; aop = 2; end
            T_AWB: begin rw = 1'b1; dn = 1'b1; end
            T_BR:  begin sa = 2'd2; aop = 1; br = 1'b1; dn = 1'b1; end
            default: begin sa = 2'd1; sb = 2'd2; pcu = 1'b1; end
        endcase
        imm = o == SW ? 2'd1 : o == BR ? 2'd2 : o == JL ? 2'd3 : 2'd0;
        if (aop == 1)      alc = 3'd1;
        else if (aop == 0) alc = 3'd0;
        else case (f3)
            3'd0:    alc = (o[5] && f7) ? 3'd1 : 3'd0;
            3'd2:    alc = 3'd5;
            3'd6:    alc = 3'd3;
            3'd7:    alc = 3'd2;
            default: alc = 3'd0;
        endcase
        return {pcu | (br & (z ^ f3[0])), adr, mw, irw, rs, sa, sb, rw, imm, alc, dn, ill};
    endfunction

    task automatic drive(input int st, input logic mr);
        MemReady = mr;
        exp_q.push_back(model(st, op, funct3, funct7b5, Zero, mr));
        @(posedge clk);
        #1;
    endtask

    // issue one instruction: queue its latency, then walk its steps with the chosen memory stalls
    task automatic issue(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                         input int fst, input int mst);
        int steps[$];
        int stalls;
        case (o)
            LW:      steps = '{T_F, T_D, T_ADR, T_RD, T_WB};
            SW:      steps = '{T_F, T_D, T_ADR, T_WR};
            RT:      steps = '{T_F, T_D, T_EXR, T_AWB};
            IT:      steps = '{T_F, T_D, T_EXI, T_AWB};
            BR:      steps = '{T_F, T_D, T_BR};
            JL:      steps = '{T_F, T_D, T_J, T_AWB};
            default: steps = '{T_F, T_D};
        endcase
        lat_q.push_back(steps.size() + fst + ((o == LW || o == SW) ? mst : 0));
        op = o; funct3 = f3; funct7b5 = f7; Zero = z;
        foreach (steps[i]) begin
            stalls = steps[i] == T_F ? fst : (steps[i] == T_RD || steps[i] == T_WR) ? mst : -1;
            if (stalls < 0) drive(steps[i], 1'($urandom));
            else begin
                for (int k = 0; k < stalls; k++) drive(steps[i], 1'b0);
                drive(steps[i], 1'b1);
            end
        end
    endtask

    // monitor: compare every cycle's outputs and each retirement's latency against the queues
    always @(negedge clk) begin
        if (!mon_en) cyc = 0;
        else begin
            if (exp_q.size() == 0) check("exp_underflow", 32'd1, 32'd0);
            else check("outputs", {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                                   RegWrite, ImmSrc, ALUControl, InstrDone, IllegalOp}, exp_q.pop_front());
            cyc++;
            if (InstrDone || IllegalOp) begin
                if (lat_q.size() == 0) check("lat_underflow", 32'd1, 32'd0);
                else check("latency", cyc, lat_q.pop_front());
                cyc = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] o;
        reset = 1'b0; MemReady = 1'b1; op = SW; funct3 = 3'b010;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_strobes", {PCWrite, IRWrite, RegWrite, MemWrite, InstrDone, IllegalOp}, 6'd0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 MemReady = 1'b0;
        @(negedge clk);
        check("memwrite_held", {MemWrite, AdrSrc, InstrDone}, 3'b110);
        #2 reset = 1'b0;
        #1 check("memwrite_drop", {MemWrite, AdrSrc}, 2'b00);
        check("fetch_async", ALUSrcB, 2'd2);
        MemReady = 1'b1;
        #1 check("irwrite_gated", {IRWrite, PCWrite}, 2'b00);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("fetch_after_release", {IRWrite, PCWrite, ALUSrcB}, 4'b1110);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1; mon_en = 1'b1;
        issue(LW, 3'b010, 1'b0, 1'b0, 0, 0);
        issue(SW, 3'b010, 1'b0, 1'b0, 0, 2);
        issue(BR, 3'b001, 1'b0, 1'b0, 0, 0);
        issue(BR, 3'b000, 1'b0, 1'b0, 1, 0);
        issue(RT, 3'b000, 1'b1, 1'b0, 0, 0);
        issue(IT, 3'b000, 1'b1, 1'b0, 0, 0);
        issue(7'b1110011, 3'b000, 1'b0, 1'b0, 0, 0);
        issue(JL, 3'b000, 1'b0, 1'b0, 2, 0);
        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 6))
                0: o = LW; 1: o = SW; 2: o = RT; 3: o = IT; 4: o = BR; 5: o = JL;
                default: do o = 7'($urandom); while (legal(o));
            endcase
            issue(o, 3'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0,
                  $urandom_range(0, 2) == 0 ? $urandom_range(1, 3) : 0);
        end
        mon_en = 1'b0;
        check("lat_drain", lat_q.size(), 32'd0);
        check("exp_drain", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have ports (all 1-bit unless stated):
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low; asserted when 0.
- op  in  7  instruction opcode (instr[6:0]).
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory completes the current access this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction and OldPC register enable.
- ResultSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU A operand: 00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  ALU B operand: 00 = rs2, 01 = ImmExt, 10 = constant 4.
- RegWrite  out  1  register-file write enable.
- ImmSrc  out  2  immediate format.
- ALUControl  out  3  ALU operation select.
- InstrDone  out  1  one-cycle pulse when an instruction retires.
- IllegalOp  out  1  one-cycle pulse when DECODE sees an unsupported opcode.

Function
REQ-002 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL; the state register is the only sequential element.
REQ-003 Transitions:
- FETCH -> DECODE on MemReady; otherwise hold.
- DECODE -> MEMADR for op 0000011 or 0100011.
- DECODE -> EXECUTER for 0110011.
- DECODE -> EXECUTEI for 0010011.
- DECODE -> BRANCH for 1100011.
- DECODE -> JAL for 1101111.
- DECODE -> FETCH for any other opcode.
REQ-004 Memory and writeback transitions:
- MEMADR -> MEMREAD for lw; MEMADR -> MEMWRITE for sw.
- MEMREAD -> MEMWB on MemReady, else hold.
- MEMWRITE -> FETCH on MemReady, else hold.
- MEMWB, ALUWB, BRANCH -> FETCH.
- EXECUTER, EXECUTEI, JAL -> ALUWB.
REQ-005 Per-state outputs; unlisted fields are 0/00:
- FETCH: IRWrite = MemReady; ALUSrcB = 10; ResultSrc = 10; PC update = MemReady.
- DECODE: ALUSrcA = 01; ALUSrcB = 01.
- MEMADR: ALUSrcA = 10; ALUSrcB = 01.
- MEMREAD: AdrSrc = 1.
- MEMWB: ResultSrc = 01; RegWrite = 1.
- MEMWRITE: AdrSrc = 1; MemWrite = 1, held until and including the MemReady cycle.
- EXECUTER: ALUSrcA = 10; ALUOp = 10.
- EXECUTEI: ALUSrcA = 10; ALUSrcB = 01; ALUOp = 10.
- ALUWB: RegWrite = 1.
- BRANCH: ALUSrcA = 10; ALUOp = 01; Branch = 1.
- JAL: ALUSrcA = 01; ALUSrcB = 10; PC update = 1.
REQ-006 PCWrite SHALL equal PC update OR (Branch AND (Zero XOR funct3[0])), so funct3 000 (beq) takes the branch on Zero = 1 and funct3 001 (bne) on Zero = 0.
REQ-007 ImmSrc SHALL be combinational from op in every state:
- 0000011 and 0010011 -> 00.
- 0100011 -> 01.
- 1100011 -> 10.
- 1101111 -> 11.
- Any other opcode -> 00.
REQ-008 ALUControl SHALL be 000 for ALUOp 00 and 001 for ALUOp 01.
REQ-009 For ALUOp 10, ALUControl SHALL decode funct3:
- 000 -> 001 (sub) when op[5] AND funct7b5 is 1, else 000 (add).
- 010 -> 101 (slt).
- 110 -> 011 (or).
- 111 -> 010 (and).
- Any other funct3 -> 000.
REQ-010 InstrDone SHALL pulse in the final cycle of each instruction: MEMWB, ALUWB, BRANCH, and MEMWRITE when MemReady = 1.
REQ-011 IllegalOp SHALL pulse in DECODE for an unsupported opcode; no register or memory write SHALL occur for that instruction.
REQ-012 Latencies with MemReady tied to 1:
- lw: 5 cycles.
- sw: 4 cycles.
- R-type, I-type ALU, jal: 4 cycles.
- branch: 3 cycles.
- Each MemReady = 0 cycle adds exactly one cycle.

Reset
REQ-013 reset = 0 SHALL force the state to FETCH immediately, without waiting for a clock edge.
REQ-014 While reset = 0, PCWrite, IRWrite, RegWrite, MemWrite, InstrDone and IllegalOp SHALL be 0.
REQ-015 Reset asserted mid-instruction SHALL abandon that instruction with no further write strobes; the first rising edge after release SHALL evaluate FETCH.

Structure
REQ-016 A shared package SHALL hold the state enum, the opcode constants, and the ALUOp, ResultSrc, ALUSrcA, ALUSrcB and ALUControl encodings.
REQ-017 The ALU decode SHALL use the existing aludec sub-module; the FSM and output logic SHALL remain in multicycle_ctrl.

Verification
REQ-018 Reset pulse during MEMWRITE, MemReady = 0 -> MemWrite drops with reset and the state is FETCH after release.
REQ-019 lw (op 0000011), MemReady = 1 -> state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite = 1 only in the 5th cycle with ResultSrc = 01.
REQ-020 sw with MemReady low for 2 cycles in MEMWRITE -> MemWrite = 1 for exactly 3 cycles; InstrDone pulses on the 3rd.
REQ-021 Branch with funct3 001, Zero = 0 -> PCWrite = 1 in BRANCH; with funct3 000, Zero = 0 -> PCWrite = 0.
REQ-022 R-type with funct3 000, funct7b5 = 1 -> ALUControl = 001 in EXECUTER; the same fields with op 0010011 -> 000.
REQ-023 op 1110011 -> IllegalOp pulses in DECODE; the next state is FETCH; RegWrite and MemWrite stay 0.
